// File: rtl/stream_decryption_engine.sv
// stream_decryption_engine: unpacks MST_DWIDTH-bit master words into SYS_DWIDTH-bit
// symbols (MSB symbol first) and decrypts each one in Caesar, Vigenere or XOR-stream
// mode against a programmable key table. Messages end at the TERMINATOR symbol.
module stream_decryption_engine #(
    parameter int                    MST_DWIDTH = 32,
    parameter int                    SYS_DWIDTH = 8,
    parameter int                    KEY_DEPTH  = 16,
    parameter logic [SYS_DWIDTH-1:0] TERMINATOR = 8'hFA,
    localparam int                   KW         = $clog2(KEY_DEPTH)
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [1:0]            mode_i,
    input  logic                  key_wr,
    input  logic [KW-1:0]         key_addr,
    input  logic [SYS_DWIDTH-1:0] key_data,
    input  logic [KW:0]           key_len,
    input  logic [MST_DWIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  busy,
    output logic [SYS_DWIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  msg_done,
    output logic                  error
);

    localparam int N  = MST_DWIDTH / SYS_DWIDTH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int KL = KW + 1;

    typedef enum logic {
        S_IDLE,
        S_UNPACK
    } state_t;

    state_t                state_q;
    logic [MST_DWIDTH-1:0] word_q;
    logic [CW-1:0]         cnt_q;
    logic [1:0]            mode_q;
    logic [KL-1:0]         klen_q;
    logic [KW-1:0]         idx_q;
    logic [KW-1:0]         idx_d;
    logic                  msg_start_q;
    logic [SYS_DWIDTH-1:0] key_q [KEY_DEPTH];

    logic [SYS_DWIDTH-1:0] sym;
    logic [SYS_DWIDTH-1:0] plain_d;
    logic [KW-1:0]         idx_last;
    logic                  cfg_err_d;

    // Current symbol, its plaintext and the key index to use for the next symbol.
    always_comb begin
        sym      = word_q[MST_DWIDTH-1 -: SYS_DWIDTH];
        idx_last = KW'(klen_q - KL'(1));
        idx_d    = idx_q;
        case (mode_q)
            2'd0:    plain_d = sym - key_q[0];
            2'd1:    plain_d = sym - key_q[idx_q];
            2'd2:    plain_d = sym ^ key_q[idx_q];
            default: plain_d = sym;
        endcase
        if (mode_q == 2'd1 || mode_q == 2'd2) begin
            idx_d = (idx_q == idx_last) ? '0 : idx_q + KW'(1);
        end
    end

    // Configuration check applied when a new message starts.
    always_comb begin
        cfg_err_d = 1'b0;
        if (mode_i == 2'd3) begin
            cfg_err_d = 1'b1;
        end else if (mode_i != 2'd0 &&
                     (key_len == '0 || key_len > KL'(KEY_DEPTH))) begin
            cfg_err_d = 1'b1;
        end
    end

    // Key table: writable only while the engine is not busy; cleared by reset.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < KEY_DEPTH; i++) begin
                key_q[i] <= '0;
            end
        end else if (key_wr && !busy) begin
            key_q[key_addr] <= key_data;
        end
    end

    // Capture/unpack FSM with registered outputs.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= '0;
            klen_q      <= '0;
            idx_q       <= '0;
            msg_start_q <= 1'b1;
            busy        <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            msg_done    <= 1'b0;
            error       <= 1'b0;
        end else begin
            valid_o  <= 1'b0;
            msg_done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid_i && !busy) begin
                        word_q  <= data_i;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= S_UNPACK;
                        if (msg_start_q) begin
                            mode_q      <= mode_i;
                            klen_q      <= key_len;
                            idx_q       <= '0;
                            msg_start_q <= 1'b0;
                            error       <= cfg_err_d;
                        end
                    end
                end
                S_UNPACK: begin
                    word_q <= word_q << SYS_DWIDTH;
                    cnt_q  <= cnt_q + CW'(1);
                    if (sym == TERMINATOR) begin
                        // Rest of the word is dropped; the next capture starts a new message.
                        msg_done    <= 1'b1;
                        busy        <= 1'b0;
                        state_q     <= S_IDLE;
                        msg_start_q <= 1'b1;
                    end else begin
                        data_o  <= plain_d;
                        valid_o <= !error;
                        idx_q   <= idx_d;
                        if (cnt_q == CW'(N - 1)) begin
                            busy    <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_decryption_engine.sv
// Self-checking bench for stream_decryption_engine: directed vectors, hand-written
// corner sequences and randomized messages checked against a behavioural model.
module tb_stream_decryption_engine;

    localparam int          N    = 4;
    localparam logic [7:0]  TERM = 8'hFA;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [1:0]  mode_i;
    logic        key_wr;
    logic [3:0]  key_addr;
    logic [7:0]  key_data;
    logic [4:0]  key_len;
    logic [31:0] data_i;
    logic        valid_i;
    logic        busy;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        msg_done;
    logic        error;

    always #5 clk_sys = ~clk_sys;

    stream_decryption_engine #(
        .MST_DWIDTH(32),
        .SYS_DWIDTH(8),
        .KEY_DEPTH (16),
        .TERMINATOR(8'hFA)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .mode_i  (mode_i),
        .key_wr  (key_wr),
        .key_addr(key_addr),
        .key_data(key_data),
        .key_len (key_len),
        .data_i  (data_i),
        .valid_i (valid_i),
        .busy    (busy),
        .data_o  (data_o),
        .valid_o (valid_o),
        .msg_done(msg_done),
        .error   (error)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state
    int  m_keys [16];
    int  m_mode;
    int  m_klen;
    int  m_idx;
    bit  m_start;
    bit  m_err;

    logic [7:0] obs [$];

    typedef struct {
        logic [1:0]  mode;
        logic [4:0]  klen;
        logic [31:0] keys;
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_keys[i] = 0;
        m_mode  = 0;
        m_klen  = 0;
        m_idx   = 0;
        m_start = 1'b1;
        m_err   = 1'b0;
    endtask

    function automatic logic [31:0] pack4(input int s);
        return {obs[s], obs[s+1], obs[s+2], obs[s+3]};
    endfunction

    // Called at a negedge while the engine is idle.
    task automatic write_key(input int addr, input int val);
        key_wr   = 1'b1;
        key_addr = addr[3:0];
        key_data = val[7:0];
        @(negedge clk_sys);
        key_wr   = 1'b0;
        m_keys[addr] = val & 8'hFF;
    endtask

    // Sends one word (called at a negedge with the engine idle) and checks every
    // symbol cycle against the model. hold keeps valid_i high and drives key_wr
    // during the busy window.
    task automatic send_word(input logic [31:0] w, input bit hold);
        int c, kv, p;
        check("idle_before_send", busy, 1'b0);
        data_i  = w;
        valid_i = 1'b1;
        if (m_start) begin
            m_mode  = mode_i;
            m_klen  = key_len;
            m_idx   = 0;
            m_start = 1'b0;
            m_err   = (m_mode == 3) ||
                      ((m_mode == 1 || m_mode == 2) && (m_klen == 0 || m_klen > 16));
        end
        @(negedge clk_sys);
        if (!hold) begin
            valid_i = 1'b0;
        end else begin
            key_wr   = 1'b1;
            key_addr = 4'd0;
            key_data = 8'h55;
        end
        check("busy_after_capture", busy, 1'b1);
        check("error_after_capture", error, m_err);
        for (int k = 0; k < N; k++) begin
            c = (w >> (8 * (N - 1 - k))) & 8'hFF;
            @(negedge clk_sys);
            if (c == TERM) begin
                check("term_msg_done", msg_done, 1'b1);
                check("term_valid_o", valid_o, 1'b0);
                check("term_busy", busy, 1'b0);
                m_start = 1'b1;
                break;
            end
            check("sym_valid_o", valid_o, !m_err);
            check("sym_msg_done", msg_done, 1'b0);
            check("sym_busy", busy, (k < N - 1));
            if (!m_err) begin
                kv = (m_mode == 0) ? m_keys[0] : m_keys[m_idx];
                case (m_mode)
                    0, 1:    p = (c - kv + 256) % 256;
                    2:       p = c ^ kv;
                    default: p = c;
                endcase
                check("sym_data_o", data_o, p);
                obs.push_back(data_o);
            end
            if ((m_mode == 1 || m_mode == 2) && m_klen != 0) m_idx = (m_idx + 1) % m_klen;
        end
        valid_i = 1'b0;
        key_wr  = 1'b0;
    endtask

    logic [31:0] rw;

    initial begin
        rst      = 1'b1;
        mode_i   = 2'd0;
        key_wr   = 1'b0;
        key_addr = '0;
        key_data = '0;
        key_len  = 5'd1;
        data_i   = '0;
        valid_i  = 1'b0;
        model_reset();

        vecs[0] = '{mode: 2'd0, klen: 5'd1, keys: 32'h03000000, word: 32'h4B4C4D4E, exp: 32'h48494A4B};
        vecs[1] = '{mode: 2'd2, klen: 5'd2, keys: 32'h0FF00000, word: 32'h12345678, exp: 32'h1DC45988};
        vecs[2] = '{mode: 2'd1, klen: 5'd4, keys: 32'h01020304, word: 32'h10203040, exp: 32'h0F1E2D3C};
        vecs[3] = '{mode: 2'd0, klen: 5'd1, keys: 32'h01000000, word: 32'h00000000, exp: 32'hFFFFFFFF};
        vecs[4] = '{mode: 2'd1, klen: 5'd1, keys: 32'h80000000, word: 32'h00017FFF, exp: 32'h8081FF7F};

        // Reset state
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid_o", valid_o, 1'b0);
        check("rst_msg_done", msg_done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_data_o", data_o, 8'h00);
        @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);

        // Caesar, four consecutive symbols
        mode_i = 2'd0;
        write_key(0, 8'h03);
        obs.delete();
        send_word(32'h4B4C4D4E, 1'b0);
        check("caesar_count", obs.size(), 4);
        if (obs.size() == 4) check("caesar_word", pack4(0), 32'h48494A4B);
        send_word(32'hFA000000, 1'b0);

        // Terminator in the middle of a word
        write_key(0, 8'h01);
        obs.delete();
        send_word(32'h41FA4243, 1'b0);
        check("midterm_count", obs.size(), 1);
        if (obs.size() == 1) check("midterm_sym", obs[0], 8'h40);

        // Vigenere with the key index carried across words
        mode_i  = 2'd1;
        key_len = 5'd3;
        write_key(0, 8'h01);
        write_key(1, 8'h02);
        write_key(2, 8'h03);
        obs.delete();
        send_word(32'h02040608, 1'b0);
        mode_i  = 2'd2;  // ignored mid-message
        key_len = 5'd1;
        send_word(32'h0A0C0E10, 1'b0);
        check("vig_count", obs.size(), 8);
        if (obs.size() == 8) begin
            check("vig_word0", pack4(0), 32'h01020307);
            check("vig_word1", pack4(4), 32'h08090D0E);
        end
        send_word(32'hFA000000, 1'b0);

        // Directed vector table
        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) write_key(i, (vecs[v].keys >> (8 * (3 - i))) & 8'hFF);
            mode_i  = vecs[v].mode;
            key_len = vecs[v].klen;
            obs.delete();
            send_word(vecs[v].word, 1'b0);
            check("table_count", obs.size(), 4);
            if (obs.size() == 4) check("table_word", pack4(0), vecs[v].exp);
            send_word(32'hFA000000, 1'b0);
        end

        // Reserved mode flags an error; next valid message clears it
        mode_i  = 2'd3;
        key_len = 5'd1;
        obs.delete();
        send_word(32'h11223344, 1'b0);
        check("err_flag", error, 1'b1);
        send_word(32'h000000FA, 1'b0);
        check("err_no_output", obs.size(), 0);
        check("err_sticky", error, 1'b1);
        mode_i = 2'd2;
        write_key(0, 8'hFF);
        send_word(32'h00000000, 1'b0);
        check("err_cleared", error, 1'b0);
        check("xor_ff_count", obs.size(), 4);
        if (obs.size() == 4) check("xor_ff_word", pack4(0), 32'hFFFFFFFF);
        send_word(32'hFA000000, 1'b0);

        // valid_i held through busy and key_wr while busy
        mode_i = 2'd0;
        write_key(0, 8'h01);
        obs.delete();
        send_word(32'h00000000, 1'b1);
        check("hold_count", obs.size(), 4);
        if (obs.size() == 4) check("hold_word", pack4(0), 32'hFFFFFFFF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            check("hold_no_recapture", valid_o, 1'b0);
        end
        obs.delete();
        send_word(32'h00000000, 1'b0);
        check("keywr_busy_ignored", obs.size() == 4 ? pack4(0) : 32'h0, 32'hFFFFFFFF);
        send_word(32'hFA000000, 1'b0);

        // Reset in the middle of a word
        write_key(0, 8'h05);
        mode_i  = 2'd0;
        data_i  = 32'h10203040;
        valid_i = 1'b1;
        @(negedge clk_sys);
        valid_i = 1'b0;
        @(negedge clk_sys);
        check("prerst_sym0", {valid_o, data_o}, {1'b1, 8'h0B});
        @(negedge clk_sys);
        check("prerst_sym1", {valid_o, data_o}, {1'b1, 8'h1B});
        rst = 1'b1;
        #1;
        check("midrst_outputs", {busy, valid_o, msg_done, error, data_o}, 12'h000);
        @(negedge clk_sys);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            check("postrst_quiet", {valid_o, msg_done, busy}, 3'b000);
        end
        obs.delete();
        send_word(32'h11223344, 1'b0);
        check("postrst_key0", obs.size() == 4 ? pack4(0) : 32'h0, 32'h11223344);
        send_word(32'hFA000000, 1'b0);
        mode_i  = 2'd1;
        key_len = 5'd16;
        obs.delete();
        for (int i = 0; i < 4; i++) send_word(32'h9ABCDE01 + i, 1'b0);
        check("postrst_table_zero", obs.size(), 16);
        send_word(32'hFA000000, 1'b0);

        // Randomized messages against the model
        for (int it = 0; it < 60; it++) begin
            repeat ($urandom_range(0, 2)) write_key($urandom_range(0, 15), $urandom_range(0, 255));
            for (int w = 0; w < int'($urandom_range(1, 3)); w++) begin
                mode_i  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                key_len = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                      : 5'($urandom_range(1, 16));
                for (int b = 0; b < 4; b++) begin
                    rw[31 - 8 * b -: 8] = ($urandom_range(0, 9) == 0) ? TERM
                                                                      : 8'($urandom_range(0, 255));
                end
                send_word(rw, 1'b0);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk_sys);
                    check("gap_quiet", {valid_o, msg_done}, 2'b00);
                end
            end
            if (!m_start) send_word(32'hFA000000, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
